// File: rtl/irrigation_timer.sv
// Per-state duration timer for the irrigation FSM: reloads on state change,
// counts down on ticks and emits a one-cycle time_over pulse when a duration elapses.
module irrigation_timer #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned T_E   = 10,
    parameter int unsigned T_A   = 20,
    parameter int unsigned T_G   = 30,
    parameter int unsigned T_L   = 15
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       state,
    input  logic             tick,
    output logic             time_over,
    output logic [WIDTH-1:0] remaining
);

    localparam logic [WIDTH-1:0] LOAD_E = WIDTH'(T_E - 32'd1);
    localparam logic [WIDTH-1:0] LOAD_A = WIDTH'(T_A - 32'd1);
    localparam logic [WIDTH-1:0] LOAD_G = WIDTH'(T_G - 32'd1);
    localparam logic [WIDTH-1:0] LOAD_L = WIDTH'(T_L - 32'd1);

    logic [1:0]       prev_state_q, prev_state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             time_over_q, time_over_d;
    logic [WIDTH-1:0] load_c;

    // Reload value for the state currently presented by the main FSM
    always_comb begin
        load_c = LOAD_E;
        unique case (state)
            2'b00:   load_c = LOAD_E;
            2'b01:   load_c = LOAD_A;
            2'b10:   load_c = LOAD_G;
            default: load_c = LOAD_L;
        endcase
    end

    // Priority: state change, pulse end, tick, hold
    always_comb begin
        prev_state_d = prev_state_q;
        count_d      = count_q;
        time_over_d  = time_over_q;
        if (state != prev_state_q) begin
            prev_state_d = state;
            count_d      = load_c;
            time_over_d  = 1'b0;
        end else if (time_over_q) begin
            time_over_d  = 1'b0;
        end else if (tick) begin
            if (count_q == '0) begin
                time_over_d = 1'b1;
                count_d     = load_c;
            end else begin
                count_d     = count_q - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prev_state_q <= 2'b00;
            count_q      <= LOAD_E;
            time_over_q  <= 1'b0;
        end else begin
            prev_state_q <= prev_state_d;
            count_q      <= count_d;
            time_over_q  <= time_over_d;
        end
    end

    assign remaining = count_q;
    assign time_over = time_over_q;

endmodule

// File: tb/tb_irrigation_timer.sv
// Directed self-checking bench for irrigation_timer with T_E=3, T_A=5, T_G=4, T_L=2.
module tb_irrigation_timer;

    localparam int unsigned WIDTH = 8;

    logic             clock;
    logic             reset;
    logic [1:0]       state;
    logic             tick;
    logic             time_over;
    logic [WIDTH-1:0] remaining;

    int checks;
    int errors;

    irrigation_timer #(
        .WIDTH(WIDTH), .T_E(3), .T_A(5), .T_G(4), .T_L(2)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .state    (state),
        .tick     (tick),
        .time_over(time_over),
        .remaining(remaining)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        checks++;
        if (remaining !== 8'd2 || time_over !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: got rem=%0d to=%0b expected rem=2 to=0", remaining, time_over);
        end
        state = 2'b01;
        tick  = 1'b1;
        cyc();
        cyc();
        checks++;
        if (remaining !== 8'd2 || time_over !== 1'b0) begin
            errors++;
            $display("FAIL reset_held: got rem=%0d to=%0b expected rem=2 to=0", remaining, time_over);
        end
        state = 2'b00;
        reset = 1'b0;
    endtask

    task automatic test_auto_restart();
        int exp_rem[8] = '{1, 0, 2, 2, 1, 0, 2, 2};
        int exp_to[8]  = '{0, 0, 1, 0, 0, 0, 1, 0};
        tick = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc();
            checks++;
            if (remaining !== WIDTH'(exp_rem[i]) || time_over !== exp_to[i][0]) begin
                errors++;
                $display("FAIL auto_restart[%0d]: got rem=%0d to=%0b expected rem=%0d to=%0d",
                         i, remaining, time_over, exp_rem[i], exp_to[i]);
            end
        end
    endtask

    task automatic test_state_change();
        int exp_rem[6] = '{4, 3, 2, 1, 0, 4};
        int exp_to[6]  = '{0, 0, 0, 0, 0, 1};
        state = 2'b01;
        tick  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc();
            checks++;
            if (remaining !== WIDTH'(exp_rem[i]) || time_over !== exp_to[i][0]) begin
                errors++;
                $display("FAIL state_change[%0d]: got rem=%0d to=%0b expected rem=%0d to=%0d",
                         i, remaining, time_over, exp_rem[i], exp_to[i]);
            end
        end
        // tick still high during the pulse cycle: no decrement
        cyc();
        checks++;
        if (remaining !== 8'd4 || time_over !== 1'b0) begin
            errors++;
            $display("FAIL tick_on_pulse: got rem=%0d to=%0b expected rem=4 to=0", remaining, time_over);
        end
    endtask

    task automatic test_mid_change();
        int exp_rem[5] = '{3, 2, 1, 0, 1};
        int exp_to[5]  = '{0, 0, 0, 0, 1};
        tick = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) state = 2'b11;
            cyc();
            checks++;
            if (remaining !== WIDTH'(exp_rem[i]) || time_over !== exp_to[i][0]) begin
                errors++;
                $display("FAIL mid_change[%0d]: got rem=%0d to=%0b expected rem=%0d to=%0d",
                         i, remaining, time_over, exp_rem[i], exp_to[i]);
            end
        end
    endtask

    task automatic test_slow_tick();
        int er;
        state = 2'b10;
        tick  = 1'b0;
        cyc();
        checks++;
        if (remaining !== 8'd3 || time_over !== 1'b0) begin
            errors++;
            $display("FAIL slow_load: got rem=%0d to=%0b expected rem=3 to=0", remaining, time_over);
        end
        for (int i = 1; i <= 18; i++) begin
            tick = (i % 4 == 0);
            cyc();
            if (i < 4)       er = 3;
            else if (i < 8)  er = 2;
            else if (i < 12) er = 1;
            else if (i < 16) er = 0;
            else             er = 3;
            checks++;
            if (remaining !== WIDTH'(er) || time_over !== (i == 16)) begin
                errors++;
                $display("FAIL slow_tick[%0d]: got rem=%0d to=%0b expected rem=%0d to=%0b",
                         i, remaining, time_over, er, (i == 16));
            end
        end
        tick = 1'b0;
    endtask

    task automatic test_async_reset();
        state = 2'b00;
        tick  = 1'b0;
        cyc();
        tick = 1'b1;
        cyc();
        checks++;
        if (remaining !== 8'd1) begin
            errors++;
            $display("FAIL pre_reset: got rem=%0d expected rem=1", remaining);
        end
        #3 reset = 1'b1;
        #1;
        checks++;
        if (remaining !== 8'd2 || time_over !== 1'b0) begin
            errors++;
            $display("FAIL reset_midcount: got rem=%0d to=%0b expected rem=2 to=0", remaining, time_over);
        end
        #1 reset = 1'b0;
        cyc();
        cyc();
        cyc();
        checks++;
        if (time_over !== 1'b1 || remaining !== 8'd2) begin
            errors++;
            $display("FAIL pulse_before_reset: got rem=%0d to=%0b expected rem=2 to=1", remaining, time_over);
        end
        #3 reset = 1'b1;
        #1;
        checks++;
        if (time_over !== 1'b0 || remaining !== 8'd2) begin
            errors++;
            $display("FAIL reset_in_pulse: got rem=%0d to=%0b expected rem=2 to=0", remaining, time_over);
        end
        // first edge after release with state != 00 reloads for the new state
        state = 2'b01;
        #1 reset = 1'b0;
        cyc();
        checks++;
        if (remaining !== 8'd4 || time_over !== 1'b0) begin
            errors++;
            $display("FAIL release_p1: got rem=%0d to=%0b expected rem=4 to=0", remaining, time_over);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        state  = 2'b00;
        tick   = 1'b0;
        #1;
        test_reset();
        test_auto_restart();
        test_state_change();
        test_mid_change();
        test_slow_tick();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/irrigation_timer.md
IRRIGATION_TIMER -- requirements
Module: irrigation_timer

Interface
REQ-001 Parameter WIDTH, default 8, is the width of the down-counter and of the remaining output.
REQ-002 Parameter T_E, default 10, is the duration of state 00 (E), in ticks.
REQ-003 Parameter T_A, default 20, is the duration of state 01 (A), in ticks.
REQ-004 Parameter T_G, default 30, is the duration of state 10 (G), in ticks.
REQ-005 Parameter T_L, default 15, is the duration of state 11 (L), in ticks.
REQ-006 Each duration SHALL be in the range 1..2^WIDTH; the value 0 is illegal and its behaviour is unspecified.
REQ-007 clock  input  1  is the single system clock; all registers update on its rising edge.
REQ-008 reset  input  1  is an asynchronous, active-high reset.
REQ-009 state  input  2  is the current state of the main irrigation FSM (00=E, 01=A, 10=G, 11=L).
REQ-010 tick  input  1  is a one-cycle time-base enable from the prescaler; the counter decrements only on tick cycles.
REQ-011 time_over  output  1  is a registered one-cycle pulse meaning the current state's duration has elapsed; it feeds the main FSM.
REQ-012 remaining  output  WIDTH  is the registered current count value, for display.

Function
REQ-013 DUR(s) SHALL select T_E, T_A, T_G or T_L for s = 00, 01, 10 or 11 respectively; the load value is DUR(s)-1, truncated to WIDTH bits.
REQ-014 Internal registers SHALL be prev_state[1:0], count[WIDTH-1:0] (driving remaining) and time_over.
REQ-015 Each rising clock edge SHALL apply exactly one of the following rules, evaluated in priority order P1 to P4.
REQ-016 P1 (state change): if state != prev_state, then prev_state<=state, count<=DUR(state)-1 and time_over<=0, and any tick in that cycle is ignored.
REQ-017 P2 (pulse end): else if time_over==1, then time_over<=0 and count holds, and any tick in that cycle is ignored.
REQ-018 P3 (tick): else if tick==1, then if count==0 the block sets time_over<=1 and count<=DUR(state)-1; otherwise it sets count<=count-1.
REQ-019 P4 (idle): otherwise all registers SHALL hold their values.
REQ-020 time_over SHALL never be high for two consecutive cycles.
REQ-021 Latency: after a state change is captured, time_over SHALL rise on the edge of the DUR(state)-th subsequent tick and stay high for exactly one cycle.
REQ-022 Auto-restart: when the FSM remains in the same state after a pulse (for example E with no irrigation request), timing SHALL restart from the reload done at P3, with no extra cycle.
REQ-023 When the FSM leaves a state on the pulse, the next edge SHALL apply P1 and reload for the new state.
REQ-024 Duration 1: count SHALL load 0, and the first following tick SHALL produce the pulse.
REQ-025 count SHALL never decrement below 0 and SHALL never wrap.
REQ-026 A state change while count is mid-run SHALL discard the remaining count without issuing a pulse.

Reset
REQ-027 While reset is high, outputs SHALL take their reset values immediately, independent of clock: prev_state=00, count=T_E-1, remaining=T_E-1, time_over=0.
REQ-028 After reset is released, the first edge SHALL apply the rules of REQ-015 to REQ-019; if state != 00 at that edge, P1 applies.
REQ-029 Reset asserted mid-count or during a pulse SHALL abort the count and clear time_over in the same instant.

Verification (T_E=3, T_A=5, T_G=4, T_L=2, WIDTH=8)
REQ-030 Reset, then state=00 held with tick every cycle -> remaining sequence is 2,1,0; time_over pulses on the 3rd tick edge, then remaining=2 again; a pulse then repeats every 4 cycles (3 ticks plus the 1-cycle pulse).
REQ-031 state changes 00->01 at cycle 10 with tick high -> the next edge gives remaining=4 and time_over=0; the pulse comes on the 5th tick after that.
REQ-032 tick asserted only every 4th cycle in state 10 -> the pulse comes 16 cycles after the load, lasts 1 cycle, and remaining=3 afterwards.
REQ-033 state changes 01->11 while remaining=2 -> remaining=1 with no pulse, and the pulse comes 2 ticks later.
REQ-034 reset pulsed asynchronously (between edges) while remaining=1 -> remaining=2 and time_over=0 immediately, before the next clock edge.
REQ-035 tick held high on the cycle where time_over=1 -> no decrement occurs on that edge and remaining still equals DUR-1.
